// File: rtl/mem_bus.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_bus : core-to-external 8-bit multiplexed bus controller
// Address phase, wait-stretched data phase, ROM write protect, slave timeout.
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_bus #(
   parameter int BITS    = 8,
   parameter int TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req,
   input  logic            we,
   input  logic            sel,
   input  logic [BITS-1:0] addr,
   input  logic [BITS-1:0] wdata,
   output logic            ack,
   output logic            err,
   output logic [BITS-1:0] rdata,
   output logic [BITS-1:0] bus_out,
   output logic            bus_oe,
   output logic            bus_ale,
   output logic            bus_we,
   output logic            bus_rom_ram,
   input  logic [BITS-1:0] bus_in,
   input  logic            bus_ready
);

   localparam int                c_CW   = $clog2(TIMEOUT + 1);
   localparam logic [c_CW-1:0]   c_LAST = c_CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_ACK  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_we;
   logic              r_sel;
   logic [BITS-1:0]   r_addr;
   logic [BITS-1:0]   r_wdata;
   logic [BITS-1:0]   r_rdata;
   logic              r_err;
   logic [c_CW-1:0]   r_cnt;
   logic              w_accept;
   logic              w_rom_wr;
   logic              w_abort;

   assign w_accept = (r_state == S_IDLE) && req;
   assign w_rom_wr = we && !sel;
   // A ready slave on the final count edge still completes normally.
   assign w_abort  = !bus_ready && (r_cnt == c_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (req) begin
               w_next = w_rom_wr ? S_ACK : S_ADDR;
            end
         end
         S_ADDR: w_next = S_DATA;
         S_DATA: begin
            if (bus_ready || w_abort) begin
               w_next = S_ACK;
            end
         end
         S_ACK:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_we    <= 1'b0;
         r_sel   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_we    <= we;
         r_sel   <= sel;
         r_addr  <= addr;
         r_wdata <= wdata;
         r_err   <= w_rom_wr;
         r_cnt   <= '0;
      end else if (r_state == S_DATA) begin
         if (bus_ready) begin
            if (!r_we) begin
               r_rdata <= bus_in;
            end
         end else if (w_abort) begin
            r_err <= 1'b1;
            if (!r_we) begin
               r_rdata <= '1;
            end
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // Bus outputs decode from registered state only, so an async reset
   // releases the bus in the same cycle.
   always_comb begin
      bus_out     = '0;
      bus_oe      = 1'b0;
      bus_ale     = 1'b0;
      bus_we      = 1'b0;
      bus_rom_ram = 1'b0;
      ack         = 1'b0;
      case (r_state)
         S_ADDR: begin
            bus_out     = r_addr;
            bus_oe      = 1'b1;
            bus_ale     = 1'b1;
            bus_rom_ram = r_sel;
         end
         S_DATA: begin
            bus_rom_ram = r_sel;
            if (r_we) begin
               bus_out = r_wdata;
               bus_oe  = 1'b1;
               bus_we  = 1'b1;
            end
         end
         S_ACK:   ack = 1'b1;
         default: ;
      endcase
   end

   assign err   = r_err;
   assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_bus : table-driven directed bench for mem_bus (BITS=8, TIMEOUT=15)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_bus;

   logic       clk = 1'b0;
   logic       reset;
   logic       req;
   logic       we;
   logic       sel;
   logic [7:0] addr;
   logic [7:0] wdata;
   logic       ack;
   logic       err;
   logic [7:0] rdata;
   logic [7:0] bus_out;
   logic       bus_oe;
   logic       bus_ale;
   logic       bus_we;
   logic       bus_rom_ram;
   logic [7:0] bus_in;
   logic       bus_ready;

   int checks = 0;
   int errors = 0;

   mem_bus #(.BITS(8), .TIMEOUT(15)) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .we          (we),
      .sel         (sel),
      .addr        (addr),
      .wdata       (wdata),
      .ack         (ack),
      .err         (err),
      .rdata       (rdata),
      .bus_out     (bus_out),
      .bus_oe      (bus_oe),
      .bus_ale     (bus_ale),
      .bus_we      (bus_we),
      .bus_rom_ram (bus_rom_ram),
      .bus_in      (bus_in),
      .bus_ready   (bus_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       we;
      logic       sel;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] bin;
      int         nr;        // not-ready samples before ready
      int         exp_cyc;   // cycle (1 = first after accept) in which ack is high
      logic       exp_err;
      logic [7:0] exp_rdata;
   } vec_t;

   vec_t vecs [7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, expv);
      end
   endtask

   task automatic bus_idle(input string name);
      chk({name, "_bus_out"}, {24'd0, bus_out}, 32'd0);
      chk({name, "_bus_ctl"}, {28'd0, bus_oe, bus_ale, bus_we, bus_rom_ram}, 32'd0);
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int  c;
      bit  got;
      req = 1'b1; we = v.we; sel = v.sel; addr = v.addr; wdata = v.wdata;
      bus_ready = 1'b0; bus_in = v.bin;
      tick();
      req = 1'b0;
      c = 1;
      got = 1'b0;
      while (!got && c <= 40) begin
         if (ack) begin
            got = 1'b1;
            chk($sformatf("v%0d_ack_cycle", idx), c, v.exp_cyc);
            chk($sformatf("v%0d_err", idx), {31'd0, err}, {31'd0, v.exp_err});
            chk($sformatf("v%0d_rdata", idx), {24'd0, rdata}, {24'd0, v.exp_rdata});
            bus_idle($sformatf("v%0d_ackcyc", idx));
         end else if (c == 1) begin
            chk($sformatf("v%0d_addr_out", idx), {24'd0, bus_out}, {24'd0, v.addr});
            chk($sformatf("v%0d_addr_ctl", idx), {28'd0, bus_oe, bus_ale, bus_we, bus_rom_ram},
                {28'd0, 1'b1, 1'b1, 1'b0, v.sel});
         end else if (v.we) begin
            chk($sformatf("v%0d_wdata_out", idx), {24'd0, bus_out}, {24'd0, v.wdata});
            chk($sformatf("v%0d_wdata_ctl", idx), {28'd0, bus_oe, bus_ale, bus_we, bus_rom_ram},
                {28'd0, 1'b1, 1'b0, 1'b1, v.sel});
         end else begin
            chk($sformatf("v%0d_rd_out", idx), {24'd0, bus_out}, 32'd0);
            chk($sformatf("v%0d_rd_ctl", idx), {28'd0, bus_oe, bus_ale, bus_we, bus_rom_ram},
                {28'd0, 1'b0, 1'b0, 1'b0, v.sel});
         end
         if (!got) begin
            bus_ready = (c >= 2) && ((c - 2) >= v.nr);
            tick();
            c++;
         end
      end
      if (!got) begin
         chk($sformatf("v%0d_ack_timeout", idx), 32'd0, 32'd1);
      end
      bus_ready = 1'b0;
      tick();
      chk($sformatf("v%0d_ack_pulse_end", idx), {31'd0, ack}, 32'd0);
      chk($sformatf("v%0d_err_hold", idx), {31'd0, err}, {31'd0, v.exp_err});
      bus_idle($sformatf("v%0d_idle", idx));
   endtask

   initial begin
      //            we    sel   addr   wdata  bin    nr  cyc err   rdata
      vecs[0] = '{1'b0, 1'b1, 8'h3C, 8'h00, 8'hA5,  0,  3, 1'b0, 8'hA5};
      vecs[1] = '{1'b1, 1'b1, 8'h10, 8'h7E, 8'h00,  2,  5, 1'b0, 8'hA5};
      vecs[2] = '{1'b1, 1'b0, 8'h05, 8'h99, 8'h00,  0,  1, 1'b1, 8'hA5};
      vecs[3] = '{1'b0, 1'b0, 8'h80, 8'h00, 8'h5A,  1,  4, 1'b0, 8'h5A};
      vecs[4] = '{1'b0, 1'b1, 8'h42, 8'h00, 8'h33, 99, 17, 1'b1, 8'hFF};
      vecs[5] = '{1'b0, 1'b1, 8'h43, 8'h00, 8'hC3, 14, 17, 1'b0, 8'hC3};
      vecs[6] = '{1'b1, 1'b1, 8'h44, 8'h55, 8'h00, 99, 17, 1'b1, 8'hC3};

      reset = 1'b0; req = 1'b0; we = 1'b0; sel = 1'b0; addr = '0; wdata = '0;
      bus_in = '0; bus_ready = 1'b0;
      tick(); tick();
      chk("reset_ack_err", {30'd0, ack, err}, 32'd0);
      chk("reset_rdata", {24'd0, rdata}, 32'd0);
      bus_idle("reset");
      reset = 1'b1;

      for (int i = 0; i < 7; i++) begin
         run_vec(i, vecs[i]);
      end

      // Async reset in the data phase of a write: bus released mid-cycle, no ack.
      req = 1'b1; we = 1'b1; sel = 1'b1; addr = 8'h20; wdata = 8'hE1; bus_ready = 1'b0;
      tick();
      req = 1'b0;
      tick();
      chk("rst_pre_we", {30'd0, bus_oe, bus_we}, 32'd3);
      #2 reset = 1'b0;
      #1;
      chk("rst_async_release", {30'd0, bus_oe, bus_we}, 32'd0);
      chk("rst_async_ack", {31'd0, ack}, 32'd0);
      tick();
      chk("rst_held_ack", {31'd0, ack}, 32'd0);
      bus_idle("rst_held");
      reset = 1'b1;
      run_vec(7, '{1'b0, 1'b1, 8'h3C, 8'h00, 8'h6B, 0, 3, 1'b0, 8'h6B});

      // req held high: ADDR, DATA, ACK, IDLE repeating.
      req = 1'b1; we = 1'b0; sel = 1'b1; addr = 8'h77; bus_ready = 1'b1; bus_in = 8'h12;
      tick();
      for (int c = 1; c <= 9; c++) begin
         chk($sformatf("b2b_c%0d_ale", c), {31'd0, bus_ale},
             {31'd0, (c == 1 || c == 5 || c == 9)});
         chk($sformatf("b2b_c%0d_ack", c), {31'd0, ack}, {31'd0, (c == 3 || c == 7)});
         tick();
      end
      req = 1'b0; bus_ready = 1'b0;
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_bus.md
# mem_bus

Memory bus controller sitting directly downstream of the CPU core. Accepts one read or write request at a time from the core (address, data, ROM/RAM select) and runs it on the shared 8-bit multiplexed external bus as an address phase followed by a data phase, stretching the data phase on wait states. Returns read data and a completion/error pulse to the core. Enforces ROM read-only access and aborts slave hangs with a timeout.

## Interface
- `BITS`, 8: address/data width.
- `TIMEOUT`, 15: consecutive not-ready data-phase samples before abort; legal range 1..255.

- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `req`  in  1  core request; sampled only in IDLE.
- `we`  in  1  1 = write, 0 = read; sampled with `req`.
- `sel`  in  1  0 = ROM, 1 = RAM; sampled with `req`.
- `addr`  in  BITS  transaction address; sampled with `req`.
- `wdata`  in  BITS  write data; sampled with `req`.
- `ack`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `ack`; 1 = ROM write rejected or timeout.
- `rdata`  out  BITS  read data; valid from `ack`, held until next read completes.
- `bus_out`  out  BITS  multiplexed address/write-data drive.
- `bus_oe`  out  1  1 = controller drives `bus_out`.
- `bus_ale`  out  1  address-latch enable (address phase).
- `bus_we`  out  1  write strobe (write data phase).
- `bus_rom_ram`  out  1  latched `sel`, held for whole transaction.
- `bus_in`  in  BITS  read data from slave.
- `bus_ready`  in  1  slave ready; sampled only in DATA.

## Operation
- States: IDLE, ADDR, DATA, ACK. All outputs are registered/decoded from registered state only; no combinational path from inputs to outputs.
- IDLE: all bus outputs 0. On edge with `req`=1, latch `we`, `sel`, `addr`, `wdata`; clear `err`, wait counter.
  - `we`=1 and `sel`=0 (ROM write): no bus cycle; go to ACK with `err`=1.
  - otherwise go to ADDR.
- ADDR (exactly 1 cycle): `bus_out`=addr, `bus_oe`=1, `bus_ale`=1, `bus_rom_ram`=sel. Next DATA.
- DATA: `bus_ale`=0, `bus_rom_ram`=sel. Write: `bus_out`=wdata, `bus_oe`=1, `bus_we`=1. Read: `bus_oe`=0, `bus_out`=0, `bus_we`=0.
  - `bus_ready`=1: read captures `bus_in` into `rdata`; go to ACK, `err`=0.
  - `bus_ready`=0 and counter = TIMEOUT-1: go to ACK, `err`=1, `rdata` := all ones (reads only; writes leave `rdata`).
  - else counter +1, stay.
- ACK (exactly 1 cycle): `ack`=1, bus outputs 0. Next IDLE unconditionally.
- `req` in ADDR/DATA/ACK is ignored; the core must drop `req` on the edge ending ACK or a new transaction starts.
- `err` holds its value after ACK until the next accepted `req`.
- Counter width ceil(log2(TIMEOUT+1)); never wraps (abort occurs first).

## Timing
- Reset (asynchronous, immediately on `reset`=0): state IDLE; `ack`, `err`, `rdata`, `bus_out`, `bus_oe`, `bus_ale`, `bus_we`, `bus_rom_ram`, counter all 0. Mid-transaction reset releases bus in the same cycle; no `ack` issued; the transaction is lost.
- Leaving reset: first `req` sampled on first rising edge with `reset`=1.
- `req` sampled at edge k: ADDR in cycle k..k+1, DATA from k+1; with `bus_ready`=1 at edge k+2, `ack` high k+2..k+3. Minimum 3 cycles request-to-ack-end; each not-ready sample adds 1.
- ROM write: `ack`/`err` high in cycle after accepting edge (1 cycle).
- Timeout: `ack`+`err` after exactly TIMEOUT not-ready samples; total = TIMEOUT+2 cycles from accept to `ack`.
- Back-to-back: earliest next accept is the edge ending the IDLE cycle after ACK (one idle cycle minimum).
- `bus_ready` and `bus_in` sampled together at the same edge; `bus_ready`=1 on the abort-count edge wins (normal completion).

## Test plan
- Read RAM, addr 0x3C, `bus_ready` tied 1, `bus_in`=0xA5 -> ADDR cycle shows `bus_out`=0x3C, `bus_ale`=1, `bus_rom_ram`=1; `ack` 3rd cycle, `rdata`=0xA5, `err`=0.
- Write RAM addr 0x10 data 0x7E, `bus_ready` low 2 cycles -> DATA lasts 3 cycles with `bus_out`=0x7E, `bus_we`=1; `ack` at cycle 5, `err`=0.
- Write ROM addr 0x05 -> no `bus_ale`/`bus_oe`; `ack`=1, `err`=1 one cycle after accept.
- Read with `bus_ready` stuck 0, TIMEOUT=15 -> `ack`+`err` at cycle 17, `rdata`=0xFF; `bus_ready`=1 on 15th sample instead -> normal completion, `err`=0.
- Pull `reset` low during DATA of a write -> `bus_oe`, `bus_we` drop same cycle, no `ack`; after release, new read completes normally.
- `req` held high continuously -> transactions accepted with exactly one IDLE cycle between each `ack` and next ADDR.
